pattern_serializer: RTL and testbench

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_pkg.sv | 16 +
 rtl/pattern_serializer.sv | 143 ++++++++++++++
 tb/tb_pattern_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern serializer.
// The PARITY state exists only when PATTERN_SERIALIZER_PARITY_EN is defined.
package pattern_pkg;

  localparam int PATTERN_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PATTERN_SERIALIZER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/pattern_serializer.sv
// LSB-first parallel-to-serial frame transmitter with one-cycle frame_done pulse.
// Optional trailing even-parity bit when PATTERN_SERIALIZER_PARITY_EN is defined.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH = PATTERN_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output state_t           fsm_state
);

  // Handshake: a frame is taken on a rising edge where load_valid && load_ready;
  // load_ready is high only in IDLE, and load_data is ignored otherwise.

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             ser_out_d;
  logic             ser_valid_d;
  logic             frame_done_d;
  logic             accept;
  logic             last_bit;
`ifdef PATTERN_SERIALIZER_PARITY_EN
  logic             par;
  logic             par_d;
`endif

  assign accept    = load_valid && load_ready;
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PATTERN_SERIALIZER_PARITY_EN
          next_state = PARITY;
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef PATTERN_SERIALIZER_PARITY_EN
      PARITY: next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Output logic computes next values of the registered serial outputs, so
  // ser_out/ser_valid/frame_done are all flop outputs.
  always_comb begin
    load_ready   = 1'b0;
    sreg_d       = sreg;
    cnt_d        = cnt;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    par_d        = par;
`endif
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sreg_d      = load_data;
          cnt_d       = '0;
          ser_out_d   = load_data[0];
          ser_valid_d = 1'b1;
`ifdef PATTERN_SERIALIZER_PARITY_EN
          par_d       = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef PATTERN_SERIALIZER_PARITY_EN
          ser_out_d    = par;
          ser_valid_d  = 1'b1;
`else
          frame_done_d = 1'b1;
`endif
        end else begin
          sreg_d      = sreg >> 1;
          cnt_d       = cnt + CW'(1);
          ser_out_d   = sreg[1];
          ser_valid_d = 1'b1;
        end
      end
`ifdef PATTERN_SERIALIZER_PARITY_EN
      PARITY: frame_done_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      cnt        <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      sreg       <= sreg_d;
      cnt        <= cnt_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      frame_done <= frame_done_d;
`ifdef PATTERN_SERIALIZER_PARITY_EN
      par        <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer (WIDTH=10); parity checks follow
// PATTERN_SERIALIZER_PARITY_EN.
module tb_pattern_serializer;
  import pattern_pkg::*;

  localparam int W = 10;
`ifdef PATTERN_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_done;
  state_t       fsm_state;

  int tests = 0;
  int fails = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [W-1:0] data;
    logic         par;
  } vec_t;

  vec_t vecs[6];

  pattern_serializer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .fsm_state  (fsm_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starting at the negedge of the first frame-bit cycle, check every bit
  // and the frame_done cycle; returns at the negedge of the frame_done cycle.
  task automatic check_bits(input logic [W-1:0] data, input logic par);
    logic [0:0] b;
    for (int n = 0; n < W; n++) exp_q.push_back(data[n]);
`ifdef PATTERN_SERIALIZER_PARITY_EN
    exp_q.push_back(par);
`else
    if (par) b = 1'b1;
`endif
    for (int n = 0; n < NB; n++) begin
      b = exp_q.pop_front();
      check("bit_valid", 32'(ser_valid), 32'd1);
      check("bit_value", 32'(ser_out), 32'(b));
      check("bit_no_done", 32'(frame_done), 32'd0);
      check("bit_busy", 32'(load_ready), 32'd0);
      @(negedge clock);
    end
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_valid", 32'(ser_valid), 32'd0);
    check("done_out", 32'(ser_out), 32'd0);
    check("done_ready", 32'(load_ready), 32'd1);
  endtask

  task automatic run_frame(input logic [W-1:0] data, input logic par, input logic hold);
    check("ready_before", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = data;
    @(posedge clock);
    @(negedge clock);
    load_valid = hold;
    load_data  = hold ? 10'h3FF : ~data;
    check_bits(data, par);
  endtask

  initial begin
    vecs[0] = '{10'b1001100111, 1'b0};
    vecs[1] = '{10'h155, 1'b1};
    vecs[2] = '{10'h2AA, 1'b1};
    vecs[3] = '{10'h001, 1'b1};
    vecs[4] = '{10'h3FF, 1'b0};
    vecs[5] = '{10'h000, 1'b0};

    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 10'h3C5;
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_valid", 32'(ser_valid), 32'd0);
    check("rst_out", 32'(ser_out), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;

    // First frame is taken on the first edge after reset; the table runs back-to-back.
    for (int i = 0; i < 6; i++) run_frame(vecs[i].data, vecs[i].par, 1'b0);
    load_valid = 1'b0;
    @(negedge clock);
    check("done_one_cycle", 32'(frame_done), 32'd0);

    // Busy loading: 3FF held valid during a frame, taken only in the frame_done cycle.
    run_frame(10'h0F0, 1'b0, 1'b1);
    @(negedge clock);
    load_valid = 1'b0;
    load_data  = 10'h000;
    check_bits(10'h3FF, 1'b0);
    @(negedge clock);

    // Reset mid-frame, asserted asynchronously between edges.
    load_valid = 1'b1;
    load_data  = 10'h2AA;
    @(posedge clock);
    @(negedge clock);
    load_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check("pre_rst_bit", 32'(ser_out), 32'((n % 2) == 1));
      check("pre_rst_valid", 32'(ser_valid), 32'd1);
      if (n < 3) @(negedge clock);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(ser_valid), 32'd0);
    check("async_rst_out", 32'(ser_out), 32'd0);
    check("async_rst_ready", 32'(load_ready), 32'd1);
    check("async_rst_done", 32'(frame_done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_frame(10'h001, 1'b1, 1'b0);
    load_valid = 1'b0;

    // Idle window.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("idle_valid", 32'(ser_valid), 32'd0);
      check("idle_out", 32'(ser_out), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
      check("idle_ready", 32'(load_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
